// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: state codes,
// opcode/funct values, ALU operation codes and datapath mux selects.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_control.sv
// R-type funct decoder: maps funct to an ALU operation code and flags
// functs the datapath does not implement.
module multicycle_control_alu_control
    import control_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_op_o,
    output logic       funct_illegal_o
);

    // funct -> ALU operation; unsupported functs fall back to ADD and flag illegal
    always_comb begin
        alu_op_o        = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: begin
                alu_op_o        = ALU_ADD;
                funct_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore main-control FSM for the multicycle MIPS-subset CPU; drives every
// datapath control input from the state register (ALUOp in EXEC also from funct).
module multicycle_control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] exec_alu_op;
    logic       funct_illegal;

    multicycle_control_alu_control u_alu_control (
        .funct_i         (funct),
        .alu_op_o        (exec_alu_op),
        .funct_illegal_o (funct_illegal)
    );

    assign state = state_q;

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; opcode only matters in DECODE/MEMADR, funct only in EXEC
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (is_mem_op(opcode)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC: begin
                if (funct_illegal) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_RWB;
                end
            end
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control outputs; reset forces everything low so no strobe fires mid-abort
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALU_AND;
        ALUSrcB     = SRCB_B;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            illegal = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADD;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH2;
                    ALUOp   = ALU_ADD;
                    illegal = !((opcode == OP_RTYPE) || is_mem_op(opcode) ||
                                (opcode == OP_BEQ) || (opcode == OP_J) ||
                                (opcode == OP_ADDI));
                end
                S_MEMADR, S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_B;
                    ALUOp   = exec_alu_op;
                    illegal = funct_illegal;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_B;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: walks each instruction class
// through its state sequence and checks every control output per cycle.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst;
    logic [3:0] state;
    logic       illegal;
    logic [17:0] ctrl;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .state       (state),
        .illegal     (illegal)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,PCSource,ALUOp,ALUSrcB,ALUSrcA,RegWrite,RegDst}
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hand-written control word for each state (EXEC takes the expected ALUOp)
    function automatic logic [17:0] exp_word(input logic [3:0] st, input logic [3:0] exec_op);
        case (st)
            4'd0:    return 18'b1_0_0_1_0_1_0_00_0010_01_0_0_0;
            4'd1:    return 18'b0_0_0_0_0_0_0_00_0010_11_0_0_0;
            4'd2:    return 18'b0_0_0_0_0_0_0_00_0010_10_1_0_0;
            4'd3:    return 18'b0_0_1_1_0_0_0_00_0000_00_0_0_0;
            4'd4:    return 18'b0_0_0_0_0_0_1_00_0000_00_0_1_0;
            4'd5:    return 18'b0_0_1_0_1_0_0_00_0000_00_0_0_0;
            4'd6:    return {9'b0_0_0_0_0_0_0_00, exec_op, 5'b00_1_0_0};
            4'd7:    return 18'b0_0_0_0_0_0_0_00_0000_00_0_1_1;
            4'd8:    return 18'b0_1_0_0_0_0_0_01_0110_00_1_0_0;
            4'd9:    return 18'b1_0_0_0_0_0_0_10_0000_00_0_0_0;
            4'd10:   return 18'b0_0_0_0_0_0_0_00_0010_10_1_0_0;
            4'd11:   return 18'b0_0_0_0_0_0_0_00_0000_00_0_1_0;
            default: return 18'b0;
        endcase
    endfunction

    task automatic check_cycle(input string tag, input logic [3:0] st, input logic [3:0] exec_op,
                               input logic ill);
        check_vec({tag, ".state"}, 32'(state), 32'(st));
        check_vec({tag, ".ctrl"}, 32'(ctrl), 32'(exp_word(st, exec_op)));
        check_vec({tag, ".illegal"}, 32'(illegal), 32'(ill));
    endtask

    // Runs one instruction from its FETCH cycle; seq holds up to 5 states, first in the top nibble
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int n, input logic [19:0] seq, input logic [3:0] exec_op,
                             input logic [3:0] ill_state);
        logic [3:0] st;
        opcode = op;
        funct  = fn;
        for (int i = 0; i < n; i++) begin
            st = seq[19 - 4*i -: 4];
            @(negedge clk);
            check_cycle($sformatf("%s[%0d]", name, i), st, exec_op, st == ill_state);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b111111;
        funct  = 6'b000000;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec("reset.state", 32'(state), 32'd0);
            check_vec("reset.ctrl", 32'(ctrl), 32'd0);
            check_vec("reset.illegal", 32'(illegal), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw",      6'b100011, 6'b000000, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 4'b0010, 4'hF);
        run_instr("sw",      6'b101011, 6'b000000, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, 4'b0010, 4'hF);
        run_instr("sub",     6'b000000, 6'b100010, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4'b0110, 4'hF);
        run_instr("add",     6'b000000, 6'b100000, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4'b0010, 4'hF);
        run_instr("and",     6'b000000, 6'b100100, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4'b0000, 4'hF);
        run_instr("or",      6'b000000, 6'b100101, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4'b0001, 4'hF);
        run_instr("slt",     6'b000000, 6'b101010, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, 4'b0111, 4'hF);
        run_instr("beq",     6'b000100, 6'b000000, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}, 4'b0010, 4'hF);
        run_instr("j",       6'b000010, 6'b000000, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}, 4'b0010, 4'hF);
        run_instr("addi",    6'b001000, 6'b000000, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 4'b0010, 4'hF);
        run_instr("bad_op",  6'b111111, 6'b000000, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 4'b0010, 4'd1);
        run_instr("bad_fn",  6'b000000, 6'b000000, 3, {4'd0, 4'd1, 4'd6, 4'd0, 4'd0}, 4'b0010, 4'd6);

        // lw interrupted by reset while in MEMRD
        run_instr("lw_abort", 6'b100011, 6'b000000, 3, {4'd0, 4'd1, 4'd2, 4'd0, 4'd0}, 4'b0010, 4'hF);
        @(negedge clk);
        check_cycle("lw_abort.memrd", 4'd3, 4'b0010, 1'b0);
        reset = 1'b1;
        #1;
        check_vec("abort.ctrl_in_reset", 32'(ctrl), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("after_abort", 6'b001000, 6'b000000, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 4'b0010, 4'hF);
        @(negedge clk);
        check_vec("final.state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
